// File: rtl/dual_port_ram_pkg.sv
// Shared defaults for the dual-port RAM: word width and address width.
// Latency: n/a (constants only).
// Backpressure: n/a.
package dual_port_ram_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_ADDR_WIDTH = 6;

endpackage : dual_port_ram_pkg

// File: rtl/dual_port_ram_port_ctrl.sv
// One RAM port: gates the write enable during reset and registers read data.
// Latency: read data appears one clock after the address is presented.
// Backpressure: none; the port accepts a read and/or write every cycle.
module dual_port_ram_port_ctrl #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  we_gated,
    output logic [DATA_WIDTH-1:0] data_out
);

    // A write is only allowed to reach the array outside of reset.
    assign we_gated = we & ~rst;

    // Output register: cleared by reset, otherwise captures the pre-write array word.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out <= '0;
        end else begin
            data_out <= rd_data;
        end
    end

endmodule : dual_port_ram_port_ctrl

// File: rtl/dual_port_ram.sv
// True dual-port synchronous RAM, two independent read/write ports on one clock.
// Latency: 1 cycle read (registered), read-first on every port and across ports.
// Backpressure: none; both ports may read or write on every cycle.
module dual_port_ram
    import dual_port_ram_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int DEPTH      = 2 ** ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in_a,
    input  logic [ADDR_WIDTH-1:0] addr_a,
    input  logic                  we_a,
    output logic [DATA_WIDTH-1:0] data_out_a,
    input  logic [DATA_WIDTH-1:0] data_in_b,
    input  logic [ADDR_WIDTH-1:0] addr_b,
    input  logic                  we_b,
    output logic [DATA_WIDTH-1:0] data_out_b
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [DATA_WIDTH-1:0] rd_a;
    logic [DATA_WIDTH-1:0] rd_b;
    logic                  wr_a;
    logic                  wr_b;

    // Array words seen by each port before this edge's writes land (read-first).
    assign rd_a = mem[addr_a];
    assign rd_b = mem[addr_b];

    dual_port_ram_port_ctrl #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_port_a (
        .clk      (clk),
        .rst      (rst),
        .we       (we_a),
        .rd_data  (rd_a),
        .we_gated (wr_a),
        .data_out (data_out_a)
    );

    dual_port_ram_port_ctrl #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_port_b (
        .clk      (clk),
        .rst      (rst),
        .we       (we_b),
        .rd_data  (rd_b),
        .we_gated (wr_b),
        .data_out (data_out_b)
    );

    // Array write: B is applied first so that A's write wins when both hit one address.
    always_ff @(posedge clk) begin
        if (wr_b) begin
            mem[addr_b] <= data_in_b;
        end
        if (wr_a) begin
            mem[addr_a] <= data_in_a;
        end
    end

endmodule : dual_port_ram

// File: tb/tb_dual_port_ram.sv
module tb_dual_port_ram;

    logic       clk;
    logic       rst;
    logic [7:0] data_in_a;
    logic [5:0] addr_a;
    logic       we_a;
    logic [7:0] data_out_a;
    logic [7:0] data_in_b;
    logic [5:0] addr_b;
    logic       we_b;
    logic [7:0] data_out_b;

    int vectors     = 0;
    int miscompares = 0;

    dual_port_ram dut (
        .clk        (clk),
        .rst        (rst),
        .data_in_a  (data_in_a),
        .addr_a     (addr_a),
        .we_a       (we_a),
        .data_out_a (data_out_a),
        .data_in_b  (data_in_b),
        .addr_b     (addr_b),
        .we_b       (we_b),
        .data_out_b (data_out_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural model: an array of words plus a "has been written" flag per word.
    logic [7:0] m_mem   [64];
    bit         m_known [64];
    logic [7:0] exp_a, exp_b;
    bit         known_a = 1'b0;
    bit         known_b = 1'b0;

    initial begin
        for (int i = 0; i < 64; i++) m_known[i] = 1'b0;
    end

    always @(posedge clk) begin
        if (rst) begin
            exp_a = 8'h00; known_a = 1'b1;
            exp_b = 8'h00; known_b = 1'b1;
        end else begin
            exp_a = m_mem[addr_a]; known_a = m_known[addr_a];
            exp_b = m_mem[addr_b]; known_b = m_known[addr_b];
            if (we_b) begin
                m_mem[addr_b] = data_in_b; m_known[addr_b] = 1'b1;
            end
            if (we_a) begin
                m_mem[addr_a] = data_in_a; m_known[addr_a] = 1'b1;
            end
        end
    end

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle compare against the model whenever the expected word is defined.
    always @(negedge clk) begin
        if (known_a) chk("model_a", data_out_a, exp_a);
        if (known_b) chk("model_b", data_out_b, exp_b);
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; we_a = 1'b0; we_b = 1'b0;
        addr_a = '0; addr_b = '0; data_in_a = '0; data_in_b = '0;
        step();
        chk("reset_a", data_out_a, 8'h00);
        chk("reset_b", data_out_b, 8'h00);
        rst = 1'b0;

        // Port A write then read
        addr_a = 6'd5; data_in_a = 8'hFF; we_a = 1'b1; step();
        we_a = 1'b0; step();
        chk("a_wr_rd", data_out_a, 8'hFF);

        // Port B write then read
        addr_b = 6'd10; data_in_b = 8'hAA; we_b = 1'b1; step();
        we_b = 1'b0; step();
        chk("b_wr_rd", data_out_b, 8'hAA);

        // A writes 8 while B reads 10
        addr_a = 6'd8; data_in_a = 8'h55; we_a = 1'b1; addr_b = 6'd10; step();
        chk("b_rd_during_a_wr", data_out_b, 8'hAA);
        we_a = 1'b0; step();
        chk("a_rd_8", data_out_a, 8'h55);

        // Simultaneous writes to different addresses
        addr_a = 6'd20; data_in_a = 8'hAB; we_a = 1'b1;
        addr_b = 6'd25; data_in_b = 8'hCD; we_b = 1'b1; step();
        we_a = 1'b0; we_b = 1'b0; step();
        chk("dual_wr_a", data_out_a, 8'hAB);
        chk("dual_wr_b", data_out_b, 8'hCD);

        // Cross-port collision at 30: seed, then A writes while B reads
        addr_a = 6'd30; data_in_a = 8'h77; we_a = 1'b1; step();
        addr_b = 6'd30; data_in_a = 8'hEF; step();
        chk("xport_old", data_out_b, 8'h77);
        we_a = 1'b0; step();
        chk("xport_new", data_out_b, 8'hEF);

        // Both ports write 30: A wins, both outputs show old content this cycle
        data_in_a = 8'h11; we_a = 1'b1; data_in_b = 8'h22; we_b = 1'b1; step();
        chk("ww_old_a", data_out_a, 8'hEF);
        chk("ww_old_b", data_out_b, 8'hEF);
        we_a = 1'b0; we_b = 1'b0; step();
        chk("ww_win_a", data_out_a, 8'h11);
        chk("ww_win_b", data_out_b, 8'h11);

        // Same-port read-first
        data_in_a = 8'h33; we_a = 1'b1; step();
        chk("rf_old", data_out_a, 8'h11);
        we_a = 1'b0; step();
        chk("rf_new", data_out_a, 8'h33);

        // Reset mid-operation suppresses the write and keeps contents
        rst = 1'b1; addr_a = 6'd5; data_in_a = 8'h00; we_a = 1'b1; step();
        chk("rst_mid_a", data_out_a, 8'h00);
        chk("rst_mid_b", data_out_b, 8'h00);
        rst = 1'b0; we_a = 1'b0; step();
        chk("rst_keep", data_out_a, 8'hFF);

        // Random traffic, biased towards address collisions, with rare resets
        for (int i = 0; i < 3000; i++) begin
            addr_a    = 6'($urandom_range(0, 63));
            addr_b    = ($urandom_range(0, 3) == 0) ? addr_a : 6'($urandom_range(0, 63));
            we_a      = 1'($urandom_range(0, 1));
            we_b      = 1'($urandom_range(0, 1));
            data_in_a = 8'($urandom);
            data_in_b = 8'($urandom);
            rst       = ($urandom_range(0, 99) == 0);
            step();
        end
        rst = 1'b0; we_a = 1'b0; we_b = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_dual_port_ram
